// File: rtl/param_accum_unit_pkg.sv
// Shared definitions for the frame accumulator: FSM state encoding and
// a width helper for the operand counter.
package param_accum_unit_pkg;

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_DONE  = 1'b1;

    typedef enum logic {
        ACCUM = ST_ACCUM,
        DONE  = ST_DONE
    } state_t;

    // Counter only needs to reach COUNT-1; keep at least one bit for COUNT=1.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/param_half_adder.sv
// WIDTH-bit adder with carry out; sum wraps modulo 2^WIDTH.
module param_half_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/param_accum_unit.sv
// Frame accumulator: sums COUNT operands through a fed-back half adder,
// counts dropped carries, and hands one result per frame downstream.
module param_accum_unit
    import param_accum_unit_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int COUNT = 4,
    localparam int CW    = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CW-1:0]    out_carries,
    output logic             out_overflow
);

    localparam int              CNTW     = cnt_width(COUNT);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(COUNT - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNTW-1:0]  cnt_reg;
    logic [CW-1:0]    carries_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_sum_reg;
    logic [CW-1:0]    out_carries_reg;
    logic             out_overflow_reg;

    logic [WIDTH-1:0] ha_sum;
    logic             ha_carry;
    logic [CW-1:0]    carries_next;

    param_half_adder #(.WIDTH(WIDTH)) ha (
        .a     (acc_reg),
        .b     (in_data),
        .sum   (ha_sum),
        .carry (ha_carry)
    );

    assign carries_next = carries_reg + CW'(ha_carry);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ACCUM;
            acc_reg          <= '0;
            cnt_reg          <= '0;
            carries_reg      <= '0;
            in_ready_reg     <= 1'b1;
            out_valid_reg    <= 1'b0;
            out_sum_reg      <= '0;
            out_carries_reg  <= '0;
            out_overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (in_valid) begin
                        acc_reg     <= ha_sum;
                        carries_reg <= carries_next;
                        if (cnt_reg == LAST_CNT) begin
                            // Result is registered on the accepting edge so
                            // out_valid rises one cycle after the last operand.
                            cnt_reg          <= '0;
                            state_reg        <= DONE;
                            in_ready_reg     <= 1'b0;
                            out_valid_reg    <= 1'b1;
                            out_sum_reg      <= ha_sum;
                            out_carries_reg  <= carries_next;
                            out_overflow_reg <= |carries_next;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg        <= ACCUM;
                        acc_reg          <= '0;
                        cnt_reg          <= '0;
                        carries_reg      <= '0;
                        in_ready_reg     <= 1'b1;
                        out_valid_reg    <= 1'b0;
                        out_sum_reg      <= '0;
                        out_carries_reg  <= '0;
                        out_overflow_reg <= 1'b0;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign out_sum      = out_sum_reg;
    assign out_carries  = out_carries_reg;
    assign out_overflow = out_overflow_reg;

endmodule
